// File: rtl/scfifo_mlab_pkg.sv
// Shared constants and helpers for the show-ahead MLAB FIFO: family names,
// family decoding and depth calculation.
package scfifo_mlab_pkg;

  typedef enum logic [1:0] {
    FAM_AGILEX,
    FAM_S10,
    FAM_LOGIC
  } family_e;

  localparam logic [127:0] FAMILY_AGILEX    = 128'("Agilex");
  localparam logic [127:0] FAMILY_S10_LONG  = 128'("Stratix 10");
  localparam logic [127:0] FAMILY_S10_SHORT = 128'("S10");
  localparam logic [127:0] FAMILY_LOGIC     = 128'("logic");

  // Unknown names fall back to plain fabric logic.
  function automatic family_e family_of(input logic [127:0] name);
    if (name == FAMILY_AGILEX) return FAM_AGILEX;
    if (name == FAMILY_S10_LONG || name == FAMILY_S10_SHORT) return FAM_S10;
    return FAM_LOGIC;
  endfunction

  function automatic bit is_hw_family(input logic [127:0] name);
    return family_of(name) != FAM_LOGIC;
  endfunction

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/mlab_sdp_mem.sv
// Simple dual-port memory with a registered, read-enabled output port.
// Stratix 10 variant adds an input register, delaying writes by one cycle.
module mlab_sdp_mem
  import scfifo_mlab_pkg::*;
#(
  parameter int           WIDTH      = 8,
  parameter int           ADDR_WIDTH = 5,
  parameter logic [127:0] FAMILY     = 128'("Agilex")
) (
  input  logic                  clk,
  input  logic [WIDTH-1:0]      din,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  output logic [WIDTH-1:0]      dout
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;

  generate
    if (family_of(FAMILY) == FAM_S10) begin : g_s10
      logic                  we_q;
      logic [ADDR_WIDTH-1:0] waddr_q;
      logic [WIDTH-1:0]      din_q;

      always_ff @(posedge clk) begin
        we_q    <= we;
        waddr_q <= waddr;
        din_q   <= din;
        if (we_q) mem_q[waddr_q] <= din_q;
      end
    end else begin : g_direct
      always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= din;
      end
    end
  endgenerate

  // Read register is intentionally unreset; it only matters once valid.
  always_ff @(posedge clk) begin
    if (re) dout_q <= mem_q[raddr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/scfifo_mlab_showahead.sv
// Single-clock show-ahead FIFO over a registered-read MLAB memory.
// Optional sticky overflow/underflow outputs with SCFIFO_MLAB_ERR_FLAGS_EN.
module scfifo_mlab_showahead
  import scfifo_mlab_pkg::*;
#(
  parameter int           WIDTH            = 8,
  parameter int           ADDR_WIDTH       = 5,
  parameter logic [127:0] FAMILY           = 128'("Agilex"),
  parameter int           ALMOST_FULL_THR  = depth_of(ADDR_WIDTH) - 4,
  parameter int           ALMOST_EMPTY_THR = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      din,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef SCFIFO_MLAB_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int            DEPTH    = depth_of(ADDR_WIDTH);
  localparam int            CW       = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(ALMOST_FULL_THR);
  localparam logic [CW-1:0] AE_C     = CW'(ALMOST_EMPTY_THR);
  localparam bit            WR_DELAY = (family_of(FAMILY) == FAM_S10);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         mem_count_q, mem_count_d;
  logic [CW-1:0]         usedw_q, usedw_d;
  logic                  ovalid_q, ovalid_d;
  logic                  full_q, full_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  wr_pend_q, wr_pend_d;
  logic                  wr_acc, pop, re, mem_inc;

  // mem_count tracks words visible in memory; on S10 a write becomes
  // readable one cycle late, so its increment is delayed to match.
  always_comb begin
    wr_acc      = wrreq & ~full_q;
    pop         = rdreq & ovalid_q;
    re          = (mem_count_q != '0) & (~ovalid_q | pop);
    mem_inc     = WR_DELAY ? wr_pend_q : wr_acc;
    wr_pend_d   = wr_acc;
    wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(wr_acc);
    rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(re);
    mem_count_d = mem_count_q + CW'(mem_inc) - CW'(re);
    usedw_d     = usedw_q + CW'(wr_acc) - CW'(pop);
    ovalid_d    = ovalid_q;
    if (re) ovalid_d = 1'b1;
    else if (pop) ovalid_d = 1'b0;
    full_d      = (usedw_d == DEPTH_C);
    af_d        = (usedw_d >= AF_C);
    ae_d        = (usedw_d < AE_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      usedw_q     <= '0;
      ovalid_q    <= 1'b0;
      full_q      <= 1'b0;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      wr_pend_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      usedw_q     <= usedw_d;
      ovalid_q    <= ovalid_d;
      full_q      <= full_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      wr_pend_q   <= wr_pend_d;
    end
  end

  mlab_sdp_mem #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FAMILY     (FAMILY)
  ) u_mem (
    .clk   (clk),
    .din   (din),
    .waddr (wr_ptr_q),
    .we    (wr_acc),
    .raddr (rd_ptr_q),
    .re    (re),
    .dout  (dout)
  );

  assign empty        = ~ovalid_q;
  assign full         = full_q;
  assign usedw        = usedw_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

`ifdef SCFIFO_MLAB_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (wrreq & full_q);
    underflow_d = underflow_q | (rdreq & ~ovalid_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_scfifo_mlab_showahead.sv
// Scoreboard bench for scfifo_mlab_showahead (default 8x32, AF=28, AE=4).
// Also exercises the error flags when SCFIFO_MLAB_ERR_FLAGS_EN is defined.
module tb_scfifo_mlab_showahead;

  localparam int DEPTH = 32;
  localparam int AF    = 28;
  localparam int AE    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       wrreq;
  logic       rdreq;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [5:0] usedw;
  logic       almost_full;
  logic       almost_empty;
`ifdef SCFIFO_MLAB_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int checks = 0;
  int errors = 0;
  int exp_used = 0;
  logic [7:0] sb[$];

  scfifo_mlab_showahead dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .wrreq        (wrreq),
    .rdreq        (rdreq),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .usedw        (usedw),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef SCFIFO_MLAB_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // One clock: drive, predict from the scoreboard, then sample #1 after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    logic do_pop, do_wr;
    wrreq  = w;
    din    = d;
    rdreq  = r;
    do_pop = r & ~empty;
    do_wr  = w & (exp_used < DEPTH);
    if (do_pop) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL pop_unexpected: dout %02h presented, expected no data", dout);
      end else begin
        if (dout !== sb[0]) begin
          errors++;
          $display("[TB] FAIL dout: got %02h expected %02h", dout, sb[0]);
        end
        void'(sb.pop_front());
      end
    end
    if (do_wr) sb.push_back(d);
    exp_used = exp_used + int'(do_wr) - int'(do_pop);
    @(posedge clk);
    #1;
    checks++;
    if (usedw !== 6'(exp_used)) begin
      errors++;
      $display("[TB] FAIL usedw: got %0d expected %0d", usedw, exp_used);
    end
    checks++;
    if (full !== (exp_used == DEPTH)) begin
      errors++;
      $display("[TB] FAIL full: got %b expected %b (usedw %0d)", full, exp_used == DEPTH, exp_used);
    end
    checks++;
    if (almost_full !== (exp_used >= AF)) begin
      errors++;
      $display("[TB] FAIL almost_full: got %b expected %b (usedw %0d)", almost_full, exp_used >= AF, exp_used);
    end
    checks++;
    if (almost_empty !== (exp_used < AE)) begin
      errors++;
      $display("[TB] FAIL almost_empty: got %b expected %b (usedw %0d)", almost_empty, exp_used < AE, exp_used);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      step(1'b0, 8'h00, 1'b1);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d words left, expected 0", sb.size());
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drain_empty: got %b expected 1", empty);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wrreq = 1'b0;
    rdreq = 1'b0;
    din   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (usedw !== 6'd0 || empty !== 1'b1 || full !== 1'b0 ||
        almost_full !== 1'b0 || almost_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_state: usedw=%0d empty=%b full=%b af=%b ae=%b expected 0 1 0 0 1",
               usedw, empty, full, almost_full, almost_empty);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    step(1'b1, 8'hA5, 1'b0);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_empty_n1: got %b expected 1", empty);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (empty !== 1'b0 || dout !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL latency_n2: empty=%b dout=%02h expected empty=0 dout=a5", empty, dout);
    end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_pop_empty: got %b expected 1", empty);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    drain();
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 8'h99, 1'b1);
    checks++;
    if (usedw !== 6'd31 || full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_rw: usedw=%0d full=%b expected 31 0", usedw, full);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (empty !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bubble: empty=1 at iteration %0d, expected 0", k);
      end
      step(1'b1, 8'(k), 1'b1);
    end
    drain();
  endtask

  task automatic test_thresholds();
    for (int i = 0; i < AF; i++) begin
      step(1'b1, 8'(8'hC0 + i), 1'b0);
      checks++;
      if (almost_full !== (i == AF - 1)) begin
        errors++;
        $display("[TB] FAIL af_edge: got %b expected %b after write %0d", almost_full, i == AF - 1, i + 1);
      end
    end
    while (exp_used > 3) step(1'b0, 8'h00, 1'b1);
    checks++;
    if (almost_empty !== 1'b1 || usedw !== 6'd3) begin
      errors++;
      $display("[TB] FAIL ae_edge: ae=%b usedw=%0d expected 1 3", almost_empty, usedw);
    end
    for (int i = 0; i < 14; i++) step(1'b1, 8'(8'hD0 + i), 1'b0);
  endtask

  task automatic test_mid_reset();
    checks++;
    if (usedw !== 6'd17) begin
      errors++;
      $display("[TB] FAIL pre_reset_usedw: got %0d expected 17", usedw);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || usedw !== 6'd0 || full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: empty=%b usedw=%0d full=%b expected 1 0 0", empty, usedw, full);
    end
    sb.delete();
    exp_used = 0;
    wrreq = 1'b1;
    din   = 8'h55;
    @(posedge clk);
    #1;
    checks++;
    if (usedw !== 6'd0) begin
      errors++;
      $display("[TB] FAIL write_in_reset: usedw=%0d expected 0", usedw);
    end
    wrreq = 1'b0;
    rst_n = 1'b1;
`ifdef SCFIFO_MLAB_ERR_FLAGS_EN
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (underflow !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL underflow_sticky: uf=%b of=%b expected 1 0", underflow, overflow);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL underflow_reset: got %b expected 0", underflow);
    end
    rst_n = 1'b1;
`endif
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_drain();
    test_full_rw();
    test_back_to_back();
    test_thresholds();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scfifo_mlab_showahead.md
Name: scfifo_mlab_showahead

Overview:
- Single-clock, show-ahead (first-word-fall-through) FIFO built on a 1-read/1-write MLAB-style memory with a registered read port.
- Generalises the plain registered-read memory into a complete buffer with pointers, occupancy count, programmable almost-full/almost-empty thresholds, and family selection.
- Used as the default shallow elastic buffer between streaming pipeline stages on Agilex, Stratix 10, or in fabric logic.

Parameters:
- WIDTH, 8, data width in bits.
- ADDR_WIDTH, 5, log2 of memory depth; DEPTH = 2**ADDR_WIDTH = capacity in words.
- FAMILY, "Agilex", one of "Agilex", "Stratix 10"/"S10", or "logic"; selects the memory implementation.
- ALMOST_FULL_THR, DEPTH-4, almost_full asserts when usedw >= this value.
- ALMOST_EMPTY_THR, 4, almost_empty asserts when usedw < this value.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous reset, active-low.
- din  in  WIDTH  write data.
- wrreq  in  1  write request.
- rdreq  in  1  read/pop request; acknowledges the current dout.
- dout  out  WIDTH  head-of-queue data; valid while empty=0.
- empty  out  1  no word is presented on dout.
- full  out  1  usedw == DEPTH.
- usedw  out  ADDR_WIDTH+1  number of accepted words not yet popped.
- almost_full  out  1  usedw >= ALMOST_FULL_THR.
- almost_empty  out  1  usedw < ALMOST_EMPTY_THR.

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n.
- Reset values: wr_ptr=0, rd_ptr=0, mem_count=0, ovalid=0, usedw=0, empty=1, full=0, almost_full=0, almost_empty=1. dout is don't-care while empty=1; the MLAB read register is not reset.
- Accept rules:
  - wr_acc = wrreq & ~full.
  - pop = rdreq & ~empty.
  - A write while full is dropped, even if rdreq is also high that cycle.
  - A read while empty is dropped, even if wrreq is also high that cycle.
- Memory write: on wr_acc, mem[wr_ptr] <= din and wr_ptr increments modulo DEPTH (natural wrap).
- Prefetch: re = (mem_count != 0) & (~ovalid | pop).
  - On re, the memory read register loads mem[rd_ptr] and rd_ptr increments modulo DEPTH.
  - The memory read register is the output stage; dout is driven directly from it.
- ovalid next state:
  - 1 if re.
  - else 0 if pop.
  - else hold.
- empty = ~ovalid.
- mem_count counts words in memory not yet prefetched: next = mem_count + wr_acc - re.
- usedw next = usedw + wr_acc - pop, registered.
- Flags:
  - full, almost_full and almost_empty are registered from usedw_next, so they change on the same edge as usedw.
  - full = (usedw_next == DEPTH).
- Latency:
  - A write in cycle N into an empty FIFO gives usedw=1 in N+1, and empty=0 with valid dout in N+2.
  - Back-to-back pops sustain one word per cycle, with no bubble, while mem_count > 0.
- Read-during-write safety: the read and write addresses are equal only when mem_count=0 (no re) or memory full (no wr_acc). The memory's mixed-port behaviour is therefore never exercised.
- Simultaneous wr_acc and pop: usedw is unchanged; full and empty are stable.
- Mid-operation reset: all contents are discarded and flags return to reset values asynchronously. wrreq/rdreq are ignored while rst_n=0; operation resumes on the first edge after deassertion.

Optional Feature:
- Macro: SCFIFO_MLAB_ERR_FLAGS_EN.
- Defined:
  - Adds outputs overflow and underflow (1 bit each), reset to 0.
  - overflow sets sticky on wrreq & full.
  - underflow sets sticky on rdreq & empty.
  - Both clear only on reset.
- Undefined: the ports are absent and dropped requests are silent.

Decomposition:
- Package scfifo_mlab_pkg holds:
  - family string constants;
  - function is_hw_family(FAMILY);
  - function depth_of(ADDR_WIDTH).
- Sub-module mlab_sdp_mem: the family-selected simple dual-port memory with registered, re-enabled read port.
  - Ports: clk, din, waddr, we, raddr, re, dout.
  - Implements tennm_mlab_cell on Agilex, fourteennm_mlab_cell with an input register on S10, and a logic array otherwise.
  - On S10, the input register adds one cycle of write latency. The FIFO compensates by delaying mem_count's increment by one cycle for that family.

Test Plan:
- Reset, then a single write of 0xA5 at cycle 0 -> usedw=1 at cycle 1, empty=0 and dout=0xA5 at cycle 2; rdreq at cycle 2 -> empty=1, usedw=0 at cycle 3.
- Write 32 words 0..31 with no reads -> full=1 and usedw=32 after the 32nd edge; a 33rd wrreq is dropped; draining gives 0..31 in order, then empty=1.
- Full FIFO with wrreq=1 and rdreq=1 for 1 cycle -> write dropped, usedw=31, full=0; data order intact.
- Steady state at usedw=10 with wrreq=rdreq=1 for 100 cycles -> usedw stays 10; dout sequence is continuous with no bubbles.
- Thresholds AF=28, AE=4: fill to 28 -> almost_full rises on the 28th accepted edge; drain to 3 -> almost_empty rises together with usedw=3.
- rst_n pulsed low with usedw=17 -> empty=1, usedw=0, full=0 immediately; with SCFIFO_MLAB_ERR_FLAGS_EN, rdreq on empty sets underflow=1, which persists until the next reset.
